// File: rtl/switch_cfg_regs_pkg.sv
// Shared types and constants for the switch configuration register bank.
package switch_cfg_regs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACK      = 2'd1,
      ST_WAIT_REL = 2'd2
   } hs_state_t;

   localparam logic [7:0] DEF_CTRL_ADDR = 8'h10;
   localparam logic [7:0] DEF_STAT_ADDR = 8'h11;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_LOCK_BIT = 1;

   localparam logic DIR_WR = 1'b1;
   localparam logic DIR_RD = 1'b0;

endpackage

// File: rtl/switch_cfg_regs_if.sv
// Memory-style request/ack bus between a configuration master and the register bank.
interface switch_cfg_regs_if;
   logic       sel_en;
   logic [7:0] addr;
   logic [7:0] wr_data;
   logic       wr_rd_s;
   logic [7:0] rd_data;
   logic       ack;

   modport master (output sel_en, addr, wr_data, wr_rd_s, input rd_data, ack);
   modport slave  (input sel_en, addr, wr_data, wr_rd_s, output rd_data, ack);
endinterface

// File: rtl/switch_cfg_regs_mem_slave_hs.sv
// Handshake FSM: turns a held sel_en into one accept pulse and one registered ack cycle.
module mem_slave_hs
   import switch_cfg_regs_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic sel_en,
   output logic accept,
   output logic ack
);

   hs_state_t state_r;
   logic      ack_r;

   // The accept pulse marks the edge on which the request is captured and committed.
   assign accept = (state_r == ST_IDLE) && sel_en;
   assign ack    = ack_r;

   // State register with registered ack, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         ack_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (sel_en) begin
                  state_r <= ST_ACK;
                  ack_r   <= 1'b1;
               end else begin
                  ack_r   <= 1'b0;
               end
            end
            ST_ACK: begin
               ack_r   <= 1'b0;
               state_r <= sel_en ? ST_WAIT_REL : ST_IDLE;
            end
            ST_WAIT_REL: begin
               ack_r <= 1'b0;
               if (!sel_en) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ack_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_cfg_regs.sv
// Switch configuration register bank: per-port destination addresses, control and status,
// accessed over a single-outstanding request/ack bus.
module switch_cfg_regs
   import switch_cfg_regs_pkg::*;
#(
   parameter int         NUM_PORTS = 4,
   parameter logic [7:0] CTRL_ADDR = DEF_CTRL_ADDR,
   parameter logic [7:0] STAT_ADDR = DEF_STAT_ADDR
) (
   input  logic                   clk,
   input  logic                   rst_n,
   switch_cfg_regs_if.slave       mem,
   output logic [NUM_PORTS*8-1:0] port_addr,
   output logic                   sw_en,
   output logic                   cfg_locked
);

   logic                   accept_s;
   logic                   ack_s;
   logic                   is_port_s;
   logic                   is_ctrl_s;
   logic                   is_stat_s;
   logic [7:0]             port_rd_s;
   logic [7:0]             rd_val_s;
   logic                   commit_s;
   logic                   err_set_s;
   logic                   err_clr_s;

   logic [NUM_PORTS*8-1:0] port_addr_r;
   logic                   sw_en_r;
   logic                   cfg_locked_r;
   logic                   err_r;
   logic [6:0]             wr_cnt_r;
   logic [7:0]             rd_data_r;

   mem_slave_hs u_hs (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel_en (mem.sel_en),
      .accept (accept_s),
      .ack    (ack_s)
   );

   assign mem.ack     = ack_s;
   assign mem.rd_data = rd_data_r;
   assign port_addr   = port_addr_r;
   assign sw_en       = sw_en_r;
   assign cfg_locked  = cfg_locked_r;

   // Address decode, read mux and commit/error qualification for the access being accepted.
   always_comb begin
      is_port_s = 1'b0;
      port_rd_s = 8'h00;
      for (int i = 0; i < NUM_PORTS; i++) begin
         is_port_s = is_port_s | (mem.addr == 8'(i));
         port_rd_s = port_rd_s | ({8{mem.addr == 8'(i)}} & port_addr_r[8*i +: 8]);
      end
      is_ctrl_s = (mem.addr == CTRL_ADDR);
      is_stat_s = (mem.addr == STAT_ADDR);

      if (is_port_s) begin
         rd_val_s = port_rd_s;
      end else if (is_ctrl_s) begin
         rd_val_s = {6'b000000, cfg_locked_r, sw_en_r};
      end else if (is_stat_s) begin
         rd_val_s = {wr_cnt_r, err_r};
      end else begin
         rd_val_s = 8'h00;
      end

      // A STAT write is a valid access (it carries the err W1C) and therefore counts as committed.
      if (accept_s && (mem.wr_rd_s == DIR_WR)) begin
         commit_s  = (is_port_s && !cfg_locked_r) || is_ctrl_s || is_stat_s;
         err_set_s = (is_port_s && cfg_locked_r) || !(is_port_s || is_ctrl_s || is_stat_s);
         err_clr_s = is_stat_s && mem.wr_data[0];
      end else if (accept_s) begin
         commit_s  = 1'b0;
         err_set_s = !(is_port_s || is_ctrl_s || is_stat_s);
         err_clr_s = 1'b0;
      end else begin
         commit_s  = 1'b0;
         err_set_s = 1'b0;
         err_clr_s = 1'b0;
      end
   end

   // Register storage, write counter, sticky error and read-data capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         port_addr_r  <= '0;
         sw_en_r      <= 1'b0;
         cfg_locked_r <= 1'b0;
         err_r        <= 1'b0;
         wr_cnt_r     <= 7'd0;
         rd_data_r    <= 8'h00;
      end else begin
         rd_data_r <= (accept_s && (mem.wr_rd_s == DIR_RD)) ? rd_val_s : 8'h00;
         if (commit_s) begin
            wr_cnt_r <= wr_cnt_r + 7'd1;
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (mem.addr == 8'(i)) begin
                  port_addr_r[8*i +: 8] <= mem.wr_data;
               end
            end
            if (is_ctrl_s) begin
               sw_en_r      <= mem.wr_data[CTRL_EN_BIT];
               cfg_locked_r <= mem.wr_data[CTRL_LOCK_BIT];
            end
         end
         if (err_set_s) begin
            err_r <= 1'b1;
         end else if (err_clr_s) begin
            err_r <= 1'b0;
         end
      end
   end

endmodule
